// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state types for the parametrised UART.
//   PAR_*      : parity selection values for the PARITY parameter
//   OVS / MID  : oversample ticks per bit and the mid-bit tick index
//   tx_state_e : transmitter states
//   rx_state_e : receiver states
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned OVS = 16;
    localparam int unsigned MID = 8;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divide-by-DIV counter producing a one-cycle oversample tick.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   restart : clears the counter so the next tick comes exactly DIV cycles later
//   tick    : one-cycle pulse every DIV cycles
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 78
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_txrx_param.sv
// uart_txrx_param: full-duplex UART, 5-9 data bits, optional parity, 1/2 stop bits.
//   clk, rst_n                      : system clock, synchronous active-low reset
//   tx_data, tx_valid, tx_ready     : transmit byte handshake
//   tx                              : serial output, idle high
//   rx                              : serial input, asynchronous
//   rx_data, rx_valid, rx_ready     : receive byte handshake (valid held until accepted)
//   rx_parity_err, rx_frame_err     : error flags qualified by rx_valid
//   rx_overrun                      : one-cycle pulse when a frame is dropped
module uart_txrx_param
    import uart_pkg::*;
#(
    parameter int unsigned DIV       = 78,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    // ---------------------------------------------------------------- TX path
    tx_state_e            r_tx_state, w_tx_state;
    logic [3:0]           r_tx_ovs, w_tx_ovs;
    logic [3:0]           r_tx_bit, w_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic                 r_tx_par, w_tx_par;
    logic                 r_tx, w_tx_line;
    logic                 w_tx_go, w_tx_tick, w_tx_bit_end;

    assign tx_ready     = (r_tx_state == TxIdle);
    assign w_tx_go      = tx_ready && tx_valid;
    assign w_tx_bit_end = w_tx_tick && (r_tx_ovs == 4'(OVS - 1));
    assign tx           = r_tx;

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_tx_go),
        .tick    (w_tx_tick)
    );

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_ovs   = r_tx_ovs;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_par   = r_tx_par;
        w_tx_line  = 1'b1;
        if (w_tx_tick && (r_tx_state != TxIdle)) begin
            w_tx_ovs = w_tx_bit_end ? 4'd0 : r_tx_ovs + 4'd1;
        end
        unique case (r_tx_state)
            TxIdle: if (tx_valid) begin
                w_tx_state = TxStart;
                w_tx_ovs   = 4'd0;
                w_tx_shift = tx_data;
                w_tx_par   = (^tx_data) ^ (PARITY == PAR_ODD);
            end
            TxStart: if (w_tx_bit_end) begin
                w_tx_state = TxData;
                w_tx_bit   = 4'd0;
            end
            TxData: if (w_tx_bit_end) begin
                w_tx_shift = r_tx_shift >> 1;
                if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                    w_tx_state = (PARITY != PAR_NONE) ? TxParity : TxStop;
                    w_tx_bit   = 4'd0;
                end else begin
                    w_tx_bit = r_tx_bit + 4'd1;
                end
            end
            TxParity: if (w_tx_bit_end) begin
                w_tx_state = TxStop;
                w_tx_bit   = 4'd0;
            end
            TxStop: if (w_tx_bit_end) begin
                if (r_tx_bit == 4'(STOP_BITS - 1)) begin
                    w_tx_state = TxIdle;
                end else begin
                    w_tx_bit = r_tx_bit + 4'd1;
                end
            end
            default: w_tx_state = TxIdle;
        endcase
        // Line level follows the next state so tx is a clean register output.
        unique case (w_tx_state)
            TxStart:  w_tx_line = 1'b0;
            TxData:   w_tx_line = w_tx_shift[0];
            TxParity: w_tx_line = w_tx_par;
            default:  w_tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_state <= TxIdle;
            r_tx_ovs   <= 4'd0;
            r_tx_bit   <= 4'd0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_ovs   <= w_tx_ovs;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_par   <= w_tx_par;
            r_tx       <= w_tx_line;
        end
    end

    // ---------------------------------------------------------------- RX path
    rx_state_e            r_rx_state, w_rx_state;
    logic [3:0]           r_rx_ovs, w_rx_ovs;
    logic [3:0]           r_rx_bit, w_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic                 r_rx_perr, w_rx_perr, r_rx_ferr, w_rx_ferr;
    logic                 r_rx_done, w_rx_done;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    logic                 w_rx_tick, w_rx_mid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_rx_perr_o, r_rx_ferr_o, r_rx_overrun;

    assign w_rx_mid = w_rx_tick && (r_rx_ovs == 4'(OVS - 1));

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (1'b0),
        .tick    (w_rx_tick)
    );

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_ovs   = r_rx_ovs;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_perr  = r_rx_perr;
        w_rx_ferr  = r_rx_ferr;
        w_rx_done  = 1'b0;
        if (w_rx_tick && (r_rx_state != RxIdle)) begin
            w_rx_ovs = r_rx_ovs + 4'd1;
        end
        unique case (r_rx_state)
            RxIdle: if (r_rx_prev && !r_rx_s2) begin
                w_rx_state = RxStart;
                w_rx_ovs   = 4'd0;
                w_rx_bit   = 4'd0;
                w_rx_perr  = 1'b0;
                w_rx_ferr  = 1'b0;
            end
            // Half a bit in: a high line here means the falling edge was a glitch.
            RxStart: if (w_rx_tick && (r_rx_ovs == 4'(MID - 1))) begin
                w_rx_ovs   = 4'd0;
                w_rx_state = r_rx_s2 ? RxIdle : RxData;
            end
            RxData: if (w_rx_mid) begin
                w_rx_ovs   = 4'd0;
                w_rx_shift = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                if (r_rx_bit == 4'(DATA_BITS - 1)) begin
                    w_rx_state = (PARITY != PAR_NONE) ? RxParity : RxStop;
                end else begin
                    w_rx_bit = r_rx_bit + 4'd1;
                end
            end
            RxParity: if (w_rx_mid) begin
                w_rx_ovs   = 4'd0;
                w_rx_perr  = r_rx_s2 ^ (^r_rx_shift) ^ (PARITY == PAR_ODD);
                w_rx_state = RxStop;
            end
            RxStop: if (w_rx_mid) begin
                w_rx_ferr  = !r_rx_s2;
                w_rx_done  = 1'b1;
                w_rx_state = RxIdle;
            end
            default: w_rx_state = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RxIdle;
            r_rx_ovs   <= 4'd0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= '0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state;
            r_rx_ovs   <= w_rx_ovs;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_rx_perr  <= w_rx_perr;
            r_rx_ferr  <= w_rx_ferr;
            r_rx_done  <= w_rx_done;
        end
    end

    // Output holding register; an accept on the same cycle frees it for the new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_perr_o  <= 1'b0;
            r_rx_ferr_o  <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (r_rx_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data   <= r_rx_shift;
                    r_rx_perr_o <= r_rx_perr;
                    r_rx_ferr_o <= r_rx_ferr;
                    r_rx_valid  <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_parity_err = r_rx_perr_o;
    assign rx_frame_err  = r_rx_ferr_o;
    assign rx_overrun    = r_rx_overrun;

endmodule

// File: tb/tb_uart_txrx_param.sv
// Bench: 8N1 loopback instance, plus a 7E1 transmitter feeding both a 7E1 and a 7O1 receiver.
module tb_uart_txrx_param;

    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 8N1 loopback, with an override on the line for glitch / broken-stop tests
    logic [7:0] tx_data8, rx_data8;
    logic       tx_valid8, tx_ready8, tx8, rx8, rx_valid8, rx_ready8;
    logic       rx_perr8, rx_ferr8, rx_ovr8;
    logic       ovr_en, ovr_val;
    assign rx8 = ovr_en ? ovr_val : tx8;

    // 7-bit even-parity sender, received under even and odd parity
    logic [6:0] tx_data7, rx_data7e, rx_data7o, tx_data7o;
    logic       tx_valid7, tx_ready7, tx7, rx_valid7e, rx_perr7e, rx_ferr7e, rx_ovr7e;
    logic       tx_ready7o, tx7o, rx_valid7o, rx_perr7o, rx_ferr7o, rx_ovr7o, one;
    assign one       = 1'b1;
    assign tx_data7o = 7'h00;

    uart_txrx_param #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data8), .tx_valid(tx_valid8),
        .tx_ready(tx_ready8), .tx(tx8), .rx(rx8), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .rx_ready(rx_ready8), .rx_parity_err(rx_perr8), .rx_frame_err(rx_ferr8),
        .rx_overrun(rx_ovr8)
    );
    uart_txrx_param #(.DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut7e (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data7), .tx_valid(tx_valid7),
        .tx_ready(tx_ready7), .tx(tx7), .rx(tx7), .rx_data(rx_data7e), .rx_valid(rx_valid7e),
        .rx_ready(one), .rx_parity_err(rx_perr7e), .rx_frame_err(rx_ferr7e),
        .rx_overrun(rx_ovr7e)
    );
    uart_txrx_param #(.DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_dut7o (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data7o), .tx_valid(1'b0),
        .tx_ready(tx_ready7o), .tx(tx7o), .rx(tx7), .rx_data(rx_data7o), .rx_valid(rx_valid7o),
        .rx_ready(one), .rx_parity_err(rx_perr7o), .rx_frame_err(rx_ferr7o),
        .rx_overrun(rx_ovr7o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Capture of every cycle with rx_valid high, sampled mid-cycle.
    int unsigned got8 = 0, got7e = 0, got7o = 0, ovr8_cnt = 0;
    logic [7:0]  cap8_data;
    logic [6:0]  cap7e_data, cap7o_data;
    logic        cap8_perr, cap8_ferr, cap7e_perr, cap7o_perr, cap7e_ferr;

    always @(negedge clk) begin
        if (rst_n && rx_valid8) begin
            got8++; cap8_data = rx_data8; cap8_perr = rx_perr8; cap8_ferr = rx_ferr8;
        end
        if (rst_n && rx_ovr8) ovr8_cnt++;
        if (rst_n && rx_valid7e) begin
            got7e++; cap7e_data = rx_data7e; cap7e_perr = rx_perr7e; cap7e_ferr = rx_ferr7e;
        end
        if (rst_n && rx_valid7o) begin
            got7o++; cap7o_data = rx_data7o; cap7o_perr = rx_perr7o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Send on the 8N1 instance; returns cycles tx_ready stayed low.
    task automatic send8(input logic [7:0] d, input bit kill_stop, output int unsigned low);
        int unsigned guard = 0;
        while (!tx_ready8 && guard < 5000) begin @(negedge clk); guard++; end
        tx_data8  = d;
        tx_valid8 = 1'b1;
        @(negedge clk);
        tx_valid8 = 1'b0;
        tx_data8  = ~d;
        low = 0;
        while (!tx_ready8 && low < 5000) begin
            // Stop bit occupies cycles 576..639 after the handshake.
            if (kill_stop) begin ovr_en = (low >= 580 && low < 630); ovr_val = 1'b0; end
            low++;
            @(negedge clk);
        end
        ovr_en = 1'b0;
    endtask

    // Send on the 7E1 instance; also samples the line mid parity bit (cycles 512..575).
    task automatic send7(input logic [6:0] d, output logic par, output int unsigned low);
        int unsigned guard = 0;
        while (!tx_ready7 && guard < 5000) begin @(negedge clk); guard++; end
        tx_data7  = d;
        tx_valid7 = 1'b1;
        @(negedge clk);
        tx_valid7 = 1'b0;
        low = 0;
        par = 1'bx;
        while (!tx_ready7 && low < 5000) begin
            if (low == 544) par = tx7;
            low++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dexp;
    } vec8_t;
    typedef struct {
        logic [6:0] din;
        logic       par_line;
        logic       perr_even;
        logic       perr_odd;
    } vec7_t;

    vec8_t       v8[5];
    vec7_t       v7[5];
    int unsigned low, base, base_o, ob;
    logic        par;

    initial begin
        v8[0] = '{8'h41, 8'h41};
        v8[1] = '{8'h00, 8'h00};
        v8[2] = '{8'hFF, 8'hFF};
        v8[3] = '{8'hA5, 8'hA5};
        v8[4] = '{8'h80, 8'h80};
        // Even parity bit on the line = XOR of data; an odd receiver always flags it.
        v7[0] = '{7'h07, 1'b1, 1'b0, 1'b1};
        v7[1] = '{7'h03, 1'b0, 1'b0, 1'b1};
        v7[2] = '{7'h55, 1'b0, 1'b0, 1'b1};
        v7[3] = '{7'h7F, 1'b1, 1'b0, 1'b1};
        v7[4] = '{7'h00, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; tx_valid8 = 1'b0; tx_valid7 = 1'b0; tx_data8 = 8'h00; tx_data7 = 7'h00;
        rx_ready8 = 1'b1; ovr_en = 1'b0; ovr_val = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx", tx8, 1);
        check("reset tx_ready", tx_ready8, 1);
        check("reset rx_valid", rx_valid8, 0);
        check("reset rx_data", rx_data8, 0);
        check("reset rx_parity_err", rx_perr8, 0);
        check("reset rx_frame_err", rx_ferr8, 0);
        check("reset rx_overrun", rx_ovr8, 0);
        check("reset tx 7e1", tx7, 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 table
        for (int i = 0; i < 5; i++) begin
            base = got8;
            send8(v8[i].din, 1'b0, low);
            for (int k = 0; k < 200 && got8 == base; k++) @(negedge clk);
            check($sformatf("8n1[%0d] frames", i), got8 - base, 1);
            check($sformatf("8n1[%0d] rx_data", i), cap8_data, v8[i].dexp);
            check($sformatf("8n1[%0d] parity_err", i), cap8_perr, 0);
            check($sformatf("8n1[%0d] frame_err", i), cap8_ferr, 0);
            check($sformatf("8n1[%0d] tx_ready low cycles", i), low, 640);
        end

        // 7-bit parity table
        for (int i = 0; i < 5; i++) begin
            base = got7e; base_o = got7o;
            send7(v7[i].din, par, low);
            for (int k = 0; k < 200 && (got7e == base || got7o == base_o); k++) @(negedge clk);
            check($sformatf("7e1[%0d] parity line", i), par, v7[i].par_line);
            check($sformatf("7e1[%0d] frames", i), got7e - base, 1);
            check($sformatf("7e1[%0d] rx_data", i), cap7e_data, v7[i].din);
            check($sformatf("7e1[%0d] parity_err", i), cap7e_perr, v7[i].perr_even);
            check($sformatf("7e1[%0d] frame_err", i), cap7e_ferr, 0);
            check($sformatf("7o1[%0d] frames", i), got7o - base_o, 1);
            check($sformatf("7o1[%0d] rx_data", i), cap7o_data, v7[i].din);
            check($sformatf("7o1[%0d] parity_err", i), cap7o_perr, v7[i].perr_odd);
            check($sformatf("7e1[%0d] tx_ready low cycles", i), low, 640);
        end

        // Start-bit glitch of 2 ticks is rejected, next frame still received.
        base = got8;
        ovr_val = 1'b0; ovr_en = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        ovr_en = 1'b0;
        repeat (100) @(negedge clk);
        check("glitch no rx_valid", got8 - base, 0);
        send8(8'h5A, 1'b0, low);
        for (int k = 0; k < 200 && got8 == base; k++) @(negedge clk);
        check("after glitch frames", got8 - base, 1);
        check("after glitch rx_data", cap8_data, 8'h5A);
        check("after glitch frame_err", cap8_ferr, 0);

        // Broken stop bit
        base = got8;
        send8(8'hC3, 1'b1, low);
        for (int k = 0; k < 200 && got8 == base; k++) @(negedge clk);
        check("bad stop frames", got8 - base, 1);
        check("bad stop rx_data", cap8_data, 8'hC3);
        check("bad stop frame_err", cap8_ferr, 1);
        repeat (50) @(negedge clk);

        // Overrun: second frame dropped while the first is unaccepted.
        rx_ready8 = 1'b0;
        ob = ovr8_cnt;
        send8(8'h11, 1'b0, low);
        repeat (20) @(negedge clk);
        check("overrun first valid", rx_valid8, 1);
        check("overrun first data", rx_data8, 8'h11);
        send8(8'h22, 1'b0, low);
        repeat (20) @(negedge clk);
        check("overrun pulses", ovr8_cnt - ob, 1);
        check("overrun data kept", rx_data8, 8'h11);
        check("overrun still valid", rx_valid8, 1);
        rx_ready8 = 1'b1;
        @(negedge clk);
        check("accept clears valid", rx_valid8, 0);
        repeat (20) @(negedge clk);

        // Reset during data bit 2 of 0x81 (a low bit), on both paths.
        base = got8;
        tx_data8 = 8'h81; tx_valid8 = 1'b1;
        @(negedge clk);
        tx_valid8 = 1'b0;
        repeat (200) @(negedge clk);
        check("mid-frame tx low before reset", tx8, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset tx", tx8, 1);
        check("mid reset tx_ready", tx_ready8, 1);
        check("mid reset rx_valid", rx_valid8, 0);
        rst_n = 1'b1;
        repeat (800) @(negedge clk);
        check("aborted frame discarded", got8 - base, 0);
        send8(8'h7E, 1'b0, low);
        for (int k = 0; k < 200 && got8 == base; k++) @(negedge clk);
        check("post reset frames", got8 - base, 1);
        check("post reset rx_data", cap8_data, 8'h7E);
        check("post reset frame_err", cap8_ferr, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
